muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Sequences the shared mult/div units and the HI/LO register pair for the multi-cycle CPU.
//   Accepts one MULT/DIV request from the main control unit and pulses the selected unit's start.
//   Waits for that unit's completion, then drives the HIGH/LOW mux selects and write enables for one cycle.
//   Reports divide-by-zero, watchdog timeout and busy status back to the control unit.
// PARAMETERS
//   TIMEOUT  40  max WAIT cycles before timeout error; must satisfy 1 <= TIMEOUT < 2**CNT_W
//   CNT_W    6   width of wait-cycle counter and last_cycles
// PORTS
//   clock         in   1      single system clock, rising edge
//   reset         in   1      asynchronous, active-low; 0 = reset
//   op_valid      in   1      request from control unit; sampled only in IDLE
//   op_is_div     in   1      0 = MULT, 1 = DIV; sampled with op_valid
//   abort         in   1      flush current op, no HI/LO write
//   mult_done     in   1      completion from mult unit
//   div_done      in   1      completion from div unit
//   div_by_zero   in   1      divide-by-zero flag from div unit
//   op_ready      out  1      1 only in IDLE
//   busy          out  1      1 in every state except IDLE
//   start_mult    out  1      1-cycle start pulse to mult unit
//   start_div     out  1      1-cycle start pulse to div unit
//   hilo_sel      out  1      select for both HI and LO muxes: 0 = mult, 1 = div
//   hi_write      out  1      HIGH register load enable
//   lo_write      out  1      LOW register load enable
//   done          out  1      1-cycle pulse: HI/LO written this cycle
//   div_zero_exc  out  1      1-cycle pulse: DIV ended by divide-by-zero
//   timeout_err   out  1      1-cycle pulse: watchdog expired
//   last_cycles   out  CNT_W  WAIT-cycle count of the last op that reached WRITE
// BEHAVIOUR
//   Reset (reset=0, asynchronous):
//     state=IDLE; op_kind=0; counter=0; hilo_sel=0; last_cycles=0; all pulse outputs 0.
//   All outputs are registered or decoded from the registered state only; no input-to-output combinational path.
//   States: IDLE, START, WAIT, WRITE, EXC, ERR.
//   IDLE:
//     op_ready=1. If op_valid=1: latch op_kind<=op_is_div, go to START.
//     abort is ignored in IDLE.
//   START (1 cycle):
//     start_mult = ~op_kind, start_div = op_kind; counter<=0; go to WAIT.
//   WAIT (evaluated each cycle, priority high to low):
//     1. abort -> IDLE; no write, no pulse.
//     2. op_kind=1 and div_by_zero -> EXC. Wins over a simultaneous div_done.
//     3. done of the selected unit -> WRITE; last_cycles<=counter+1.
//     4. counter==TIMEOUT-1 -> ERR.
//     5. otherwise counter<=counter+1.
//     The done of the non-selected unit, and div_by_zero during a MULT, are ignored.
//   WRITE (1 cycle):
//     hi_write=lo_write=1, done=1; go to IDLE. HI/LO hold new values from the next cycle.
//     abort is ignored in WRITE.
//   EXC (1 cycle):
//     div_zero_exc=1; HI/LO not written; go to IDLE.
//   ERR (1 cycle):
//     timeout_err=1; HI/LO not written; go to IDLE.
//   hilo_sel = op_kind in every non-IDLE state; keeps its last value in IDLE.
//   op_valid outside IDLE is dropped, not queued; control unit must wait for op_ready.
//   Latency: op accepted at edge 0 -> START cycle 1 -> WAIT from cycle 2.
//     Unit done seen in WAIT cycle 2+k -> WRITE at cycle 3+k; op_ready again at cycle 4+k.
//   Back-to-back: a new op_valid in the first IDLE cycle after WRITE/EXC/ERR is accepted.
//   Counter saturates implicitly: ERR is taken before it can wrap.
//   Reset asserted mid-operation: immediate return to IDLE, all pulses 0, HI/LO untouched.
// TESTING
//   T1 MULT: op_valid,op_is_div=0; mult_done at 5th WAIT cycle
//      -> start_mult 1 cycle; WRITE with hilo_sel=0; done once; last_cycles=5.
//   T2 DIV: op_is_div=1; div_done at 3rd WAIT cycle
//      -> start_div only; hilo_sel=1 during WRITE; hi_write=lo_write=1 for 1 cycle; last_cycles=3.
//   T3 DIV: div_by_zero and div_done in the same WAIT cycle
//      -> EXC; div_zero_exc 1 cycle; hi_write never asserted; last_cycles unchanged.
//   T4 MULT with mult_done never asserted, TIMEOUT=40
//      -> timeout_err exactly 40 WAIT cycles after START; then op_ready=1.
//   T5 MULT: div_done pulsed in WAIT, then abort in WAIT
//      -> div_done ignored; abort returns to IDLE next cycle; no done, no write.
//      -> op_valid during busy is dropped.
//   T6 reset driven low in WAIT
//      -> outputs 0 and op_ready=1 without a clock edge; then a fresh MULT completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multiply/divide units and the HI/LO register pair.
// Issues one start pulse, waits for completion, then writes HI/LO or reports an exception.
module muldiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_is_div,
    input  logic             abort,
    input  logic             mult_done,
    input  logic             div_done,
    input  logic             div_by_zero,
    output logic             op_ready,
    output logic             busy,
    output logic             start_mult,
    output logic             start_div,
    output logic             hilo_sel,
    output logic             hi_write,
    output logic             lo_write,
    output logic             done,
    output logic             div_zero_exc,
    output logic             timeout_err,
    output logic [CNT_W-1:0] last_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WRITE,
        S_EXC,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             op_kind_q, op_kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             unit_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_kind_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_kind_q <= op_kind_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    // Only the done of the unit that was started counts.
    assign unit_done = op_kind_q ? div_done : mult_done;

    always_comb begin
        state_d   = state_q;
        op_kind_d = op_kind_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_kind_d = op_is_div;
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (op_kind_q && div_by_zero) begin
                    state_d = S_EXC;
                end else if (unit_done) begin
                    state_d = S_WRITE;
                    last_d  = cnt_q + CNT_W'(1);
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE, S_EXC, S_ERR: state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // op_kind only changes on acceptance, so it doubles as the held mux select in IDLE.
    always_comb begin
        op_ready     = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
        start_mult   = (state_q == S_START) && !op_kind_q;
        start_div    = (state_q == S_START) &&  op_kind_q;
        hilo_sel     = op_kind_q;
        hi_write     = (state_q == S_WRITE);
        lo_write     = (state_q == S_WRITE);
        done         = (state_q == S_WRITE);
        div_zero_exc = (state_q == S_EXC);
        timeout_err  = (state_q == S_ERR);
        last_cycles  = last_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboarded bench for muldiv_sequencer: each op pushes its expected terminal event,
// a negedge monitor pops and compares when done/div_zero_exc/timeout_err pulses.
module tb_muldiv_sequencer;

    localparam int CNT_W   = 6;
    localparam int TIMEOUT = 40;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             op_valid = 1'b0;
    logic             op_is_div = 1'b0;
    logic             abort = 1'b0;
    logic             mult_done = 1'b0;
    logic             div_done = 1'b0;
    logic             div_by_zero = 1'b0;
    logic             op_ready, busy, start_mult, start_div, hilo_sel;
    logic             hi_write, lo_write, done, div_zero_exc, timeout_err;
    logic [CNT_W-1:0] last_cycles;

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_is_div    (op_is_div),
        .abort        (abort),
        .mult_done    (mult_done),
        .div_done     (div_done),
        .div_by_zero  (div_by_zero),
        .op_ready     (op_ready),
        .busy         (busy),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .hilo_sel     (hilo_sel),
        .hi_write     (hi_write),
        .lo_write     (lo_write),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_err  (timeout_err),
        .last_cycles  (last_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]       ev;    // {done, div_zero_exc, timeout_err}
        logic             sel;
        logic [CNT_W-1:0] last;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_smul = 0;
    int   n_sdiv = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (start_mult) n_smul++;
        if (start_div)  n_sdiv++;
        if (done)       n_done++;
        if (done || div_zero_exc || timeout_err) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_event", {29'd0, done, div_zero_exc, timeout_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ev_kind", {29'd0, done, div_zero_exc, timeout_err}, {29'd0, e.ev});
                chk("hi_write", hi_write, e.ev[2]);
                chk("lo_write", lo_write, e.ev[2]);
                chk("hilo_sel", hilo_sel, e.sel);
                chk("last_cycles", last_cycles, e.last);
            end
        end else begin
            chk("write_idle", {30'd0, hi_write, lo_write}, 32'd0);
        end
        chk("busy_vs_ready", busy, !op_ready);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [2:0] ev, input logic sel, input logic [CNT_W-1:0] last);
        exp_t e;
        e.ev = ev; e.sel = sel; e.last = last;
        sb_q.push_back(e);
    endtask

    // Ends in the START cycle.
    task automatic issue(input logic div);
        int n = 0;
        while (!op_ready && n < 100) begin
            step();
            n++;
        end
        chk("issue_ready", op_ready, 1'b1);
        op_valid = 1'b1;
        op_is_div = div;
        step();
        op_valid = 1'b0;
        op_is_div = 1'b0;
        chk("start_mult", start_mult, !div);
        chk("start_div", start_div, div);
        chk("sel_start", hilo_sel, div);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sel", hilo_sel, 1'b0);
        chk("rst_last", last_cycles, 6'd0);
        chk("rst_pulses", {start_mult, start_div, done, div_zero_exc, timeout_err}, 5'd0);
        #14 reset = 1'b1;
        step();

        // T1 MULT, done at 5th WAIT cycle
        issue(1'b0);
        steps(5);
        push(3'b100, 1'b0, 6'd5);
        mult_done = 1'b1;
        step();
        mult_done = 1'b0;
        chk("t1_done", done, 1'b1);
        step();
        chk("t1_ready", op_ready, 1'b1);

        // T2 DIV back-to-back, done at 3rd WAIT cycle
        issue(1'b1);
        steps(3);
        push(3'b100, 1'b1, 6'd3);
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        chk("t2_write", hi_write, 1'b1);
        step();
        chk("t2_ready", op_ready, 1'b1);
        chk("t2_sel_hold", hilo_sel, 1'b1);

        // T3 DIV: div_by_zero beats div_done
        issue(1'b1);
        step();
        push(3'b010, 1'b1, 6'd3);
        div_by_zero = 1'b1;
        div_done = 1'b1;
        step();
        div_by_zero = 1'b0;
        div_done = 1'b0;
        chk("t3_exc", div_zero_exc, 1'b1);
        step();
        chk("t3_ready", op_ready, 1'b1);
        chk("t3_last", last_cycles, 6'd3);

        // T4 MULT timeout: ERR exactly TIMEOUT WAIT cycles after START
        issue(1'b0);
        steps(TIMEOUT);
        chk("t4_no_err_yet", timeout_err, 1'b0);
        push(3'b001, 1'b0, 6'd3);
        step();
        chk("t4_err", timeout_err, 1'b1);
        step();
        chk("t4_ready", op_ready, 1'b1);

        // T5 MULT: foreign done and div_by_zero ignored, dropped op_valid, abort
        issue(1'b0);
        step();
        div_done = 1'b1;
        div_by_zero = 1'b1;
        op_valid = 1'b1;
        op_is_div = 1'b1;
        step();
        div_done = 1'b0;
        div_by_zero = 1'b0;
        op_valid = 1'b0;
        op_is_div = 1'b0;
        chk("t5_still_busy", busy, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_idle", op_ready, 1'b1);
        chk("t5_sel", hilo_sel, 1'b0);
        step();
        chk("t5_no_start", {start_mult, start_div}, 2'd0);
        chk("t5_stay_idle", op_ready, 1'b1);

        // T6 asynchronous reset during WAIT of a DIV
        issue(1'b1);
        steps(3);
        #2 reset = 1'b0;
        #1;
        chk("t6_ready", op_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_sel", hilo_sel, 1'b0);
        chk("t6_last", last_cycles, 6'd0);
        step();
        #2 reset = 1'b1;
        step();
        issue(1'b0);
        steps(2);
        push(3'b100, 1'b0, 6'd2);
        mult_done = 1'b1;
        step();
        mult_done = 1'b0;
        chk("t6_done", done, 1'b1);
        step();
        chk("t6_ready2", op_ready, 1'b1);
        chk("t6_last2", last_cycles, 6'd2);
        step();

        chk("sb_empty", sb_q.size(), 32'd0);
        chk("n_done", n_done, 32'd3);
        chk("n_start_mult", n_smul, 32'd4);
        chk("n_start_div", n_sdiv, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
